// File: rtl/sram1rw256x48_ctrl.sv
// sram1rw256x48_ctrl: request/response front end for a 256x48 single-port
// synchronous SRAM. The SRAM CE pin shares clk.
// A read is issued in cycle N. The SRAM drives its output in N+1 and the
// data is captured at the end of N+1 into a 2-entry in-order response FIFO.
// Optional feature macro: SRAM_CTRL_RMW_EN. When it is defined, a write with
// a partial byte mask is done as a read-modify-write through a small FSM.
// Without it, the byte mask is ignored and every write stores a full word.
module sram1rw256x48_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   sram_a,
  output logic                sram_csb,
  output logic                sram_web,
  output logic                sram_oeb,
  output logic [DATA_W-1:0]   sram_i,
  input  logic [DATA_W-1:0]   sram_o
);
  localparam int MASK_W = DATA_W / 8;

  logic              r_rd_p1;   // a response-producing read was issued last cycle
  logic              r_oe_p1;   // any SRAM read (normal or RMW) was issued last cycle
  logic [1:0]        r_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_fifo [2];

  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_space;
  logic              w_idle;
  logic              w_rd_issue;  // normal read: will produce a response
  logic              w_sram_rd;   // any SRAM read this cycle
  logic              w_access;    // request drives an SRAM access this cycle
  logic              w_wr_issue;  // request is a single-cycle full-word write
  logic              w_rmw_wr;    // second (write) cycle of an RMW
  logic [ADDR_W-1:0] w_rmw_addr;
  logic [DATA_W-1:0] w_rmw_data;

  // Reads in flight count against FIFO space; a pop this cycle frees a slot.
  assign w_space   = ({1'b0, r_cnt} + {2'b00, r_rd_p1}) < (3'd2 + {2'b00, w_pop});
  assign req_ready = ~rst & w_idle & w_space;
  assign w_fire    = req_valid & req_ready;
  assign rsp_valid = ~rst & (r_cnt != 2'd0);
  assign rsp_rdata = r_fifo[r_rd_ptr];
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_rd_p1;
  assign sram_oeb  = rst | ~r_oe_p1;

`ifdef SRAM_CTRL_RMW_EN
  typedef enum logic {ST_IDLE, ST_RMW_WR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rmw_addr;
  logic [DATA_W-1:0] r_rmw_wdata;
  logic [MASK_W-1:0] r_rmw_mask;
  logic              w_mask_full;
  logic              w_mask_none;
  logic              w_rmw_start;

  // Keep old bytes where the mask is clear, take new bytes where it is set.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_d,
                                                    input logic [DATA_W-1:0] new_d,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int k = 0; k < MASK_W; k++)
      if (mask[k]) res[8*k +: 8] = new_d[8*k +: 8];
    return res;
  endfunction

  assign w_mask_full = &req_wmask;
  assign w_mask_none = ~|req_wmask;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_rmw_wr    = (r_state == ST_RMW_WR);
  // The accepting cycle is the RMW read phase; the write follows next cycle.
  assign w_rmw_start = w_fire & req_we & ~w_mask_full & ~w_mask_none;
  assign w_rd_issue  = w_fire & ~req_we;
  assign w_sram_rd   = w_rd_issue | w_rmw_start;
  assign w_wr_issue  = w_fire & req_we & w_mask_full;
  assign w_access    = w_fire & ~(req_we & w_mask_none);
  assign w_rmw_addr  = r_rmw_addr;
  assign w_rmw_data  = merge_lanes(sram_o, r_rmw_wdata, r_rmw_mask);

  // RMW sequencer: IDLE -> RMW_WR for one cycle -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_rmw_start) r_state <= ST_RMW_WR;
        ST_RMW_WR: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Hold the partial write's address, data and mask for the write phase.
  always_ff @(posedge clk) begin
    if (w_rmw_start) begin
      r_rmw_addr  <= req_addr;
      r_rmw_wdata <= req_wdata;
      r_rmw_mask  <= req_wmask;
    end
  end
`else
  logic w_unused_mask;

  // The byte mask has no effect: every write stores the whole word.
  assign w_unused_mask = ^req_wmask;
  assign w_idle        = 1'b1;
  assign w_rmw_wr      = 1'b0;
  assign w_rd_issue    = w_fire & ~req_we;
  assign w_sram_rd     = w_rd_issue;
  assign w_wr_issue    = w_fire & req_we;
  assign w_access      = w_fire;
  assign w_rmw_addr    = '0;
  assign w_rmw_data    = '0;
`endif

  // SRAM pins are driven combinationally in the issue cycle and parked when idle.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_i   = '0;
    if (!rst) begin
      if (w_rmw_wr) begin
        sram_csb = 1'b0;
        sram_web = 1'b0;
        sram_a   = w_rmw_addr;
        sram_i   = w_rmw_data;
      end else if (w_access) begin
        sram_csb = 1'b0;
        sram_web = ~w_wr_issue;
        sram_a   = req_addr;
        sram_i   = req_wdata;
      end
    end
  end

  // Read-in-flight flags and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_p1  <= 1'b0;
      r_oe_p1  <= 1'b0;
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_rd_p1 <= w_rd_issue;
      r_oe_p1 <= w_sram_rd;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Capture SRAM output at the end of the cycle after a read issue.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= sram_o;
  end
endmodule

// File: doc/sram1rw256x48_ctrl.md
SRAM1RW256X48_CTRL -- requirements
Module: sram1rw256x48_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, SRAM address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 48, SRAM word width; lane count MASK_W = DATA_W/8 = 6.
REQ-003 SHALL have port clk  input  1  single clock; the SRAM CE pin connects to this same clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid (fire).
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port req_wmask  input  MASK_W  per-byte write enable, bit k covers data[8k+7:8k].
REQ-011 SHALL have port rsp_valid  output  1  read data available.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes rsp_rdata when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data, in request order.
REQ-014 SHALL have ports sram_a (output, ADDR_W), sram_csb (output, 1), sram_web (output, 1), sram_oeb (output, 1), sram_i (output, DATA_W) and sram_o (input, DATA_W), all driving or receiving the SRAM pins of the same names.

Function
REQ-015 SHALL drive SRAM pins combinationally in issue cycle N: sram_csb=0, sram_web=~we, sram_a=addr, sram_i=data; idle cycles drive csb=1, web=1.
REQ-016 SHALL drive sram_oeb=0 only in cycle N+1 after a read issue; otherwise 1, so sram_o may be Z.
REQ-017 SHALL capture sram_o at the end of cycle N+1 into a 2-entry in-order response FIFO; rsp_valid rises in N+2 (latency 2 with an empty FIFO).
REQ-018 SHALL produce no response for writes.
REQ-019 SHALL deassert req_ready unless (FIFO occupancy + reads in flight) < 2, counting a same-cycle pop as freeing a slot; the FIFO SHALL never overflow and a read SHALL never be dropped.
REQ-020 SHALL support a simultaneous FIFO push and pop at any occupancy 0..2 with the count unchanged.
REQ-021 SHALL sustain one accepted request per cycle when rsp_ready is held high and no RMW is in progress.
REQ-022 SHALL return new data for a write to A at N followed by a read of A at N+1.
REQ-023 SHALL hold rsp_rdata stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-024 SHALL, while rst=1: req_ready=0, rsp_valid=0, sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0.
REQ-025 SHALL, on rst asserted mid-operation: flush the FIFO, discard in-flight reads, return the FSM to IDLE, and treat the first cycle after rst falls as idle with an empty FIFO.

Configuration
REQ-026 SHALL, with SRAM_CTRL_RMW_EN defined, handle a write whose mask is not all ones by RMW: FSM IDLE -> RMW_RD (issue read, cycle N) -> RMW_WR (cycle N+1: merge sram_o with masked wdata, issue write, req_ready=0) -> IDLE; a mask of all zeros SHALL be accepted and issue no SRAM access.
REQ-027 SHALL, with SRAM_CTRL_RMW_EN defined, keep a full-mask write single-cycle and return no response for an RMW.
REQ-028 SHALL, without SRAM_CTRL_RMW_EN, ignore req_wmask, write full words in one cycle, and contain no FSM.

Verification
REQ-029 SHALL cover: write A=0x10 D=0x123456789ABC, then read A=0x10 -> rsp_rdata=0x123456789ABC, rsp_valid in issue cycle +2.
REQ-030 SHALL cover: reads of 0..7 back-to-back with rsp_ready=1 -> req_ready never low, 8 responses in order.
REQ-031 SHALL cover: rsp_ready=0, issue 3 reads -> third stalls (req_ready=0), two held; release -> all 3 returned in order.
REQ-032 SHALL cover (RMW_EN): mem[5]=0xFFFFFFFFFFFF, write D=0 mask=6'b000011 -> req_ready low one cycle; read 5 -> 0xFFFFFFFF0000.
REQ-033 SHALL cover: rst pulsed one cycle after a read issue -> no rsp_valid ever for that read, and all REQ-024 values hold.
